// File: rtl/fifo_port_arbiter.sv
// Round-robin arbiter sharing fifo_top's write port among NUM_REQ producers and gating reads via a shadow count; all outputs registered, 1-cycle latency.
// Never writes when full or reads when empty. FIFO_ARB_PRIO0_EN gives requester 0 strict priority over the round robin.
module fifo_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 8,
  parameter int DEPTH   = 16,
  parameter int CW      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_REQ-1:0]    wr_req,
  input  logic [NUM_REQ*DW-1:0] wr_data,
  output logic [NUM_REQ-1:0]    wr_gnt,
  input  logic                  rd_req,
  output logic                  rd_gnt,
  output logic                  fifo_write_signal,
  output logic                  fifo_read_signal,
  output logic [DW-1:0]         fifo_data_in,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] r_wr_gnt;
  logic               r_rd_gnt;
  logic               r_wr_sig;
  logic               r_rd_sig;
  logic [DW-1:0]      r_data;
  logic [CW-1:0]      r_count;
  logic               r_full;
  logic               r_empty;
  logic [PW-1:0]      r_rr_ptr;

  logic               w_rr_hit;
  logic [PW-1:0]      w_rr_idx;
  logic [PW-1:0]      w_cand;
  logic               w_prio_hit;
  logic               w_wr_ok;
  logic               w_rd_ok;
  logic [PW-1:0]      w_gnt_idx;
  logic [PW-1:0]      w_ptr_nxt;
  logic [NUM_REQ-1:0] w_gnt_vec;
  logic [CW-1:0]      w_cnt_nxt;

  // Ascending search from r_rr_ptr with wrap; first requesting index wins.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    w_cand   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (int'(r_rr_ptr) + off >= NUM_REQ) w_cand = PW'(int'(r_rr_ptr) + off - NUM_REQ);
      else                                 w_cand = PW'(int'(r_rr_ptr) + off);
      if (!w_rr_hit && wr_req[w_cand]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_cand;
      end
    end
  end

`ifdef FIFO_ARB_PRIO0_EN
  assign w_prio_hit = wr_req[0];
`else
  assign w_prio_hit = 1'b0;
`endif

  assign w_wr_ok   = en && (|wr_req) && (r_count < CW'(DEPTH));
  assign w_rd_ok   = en && rd_req && (r_count != '0);
  assign w_gnt_idx = w_prio_hit ? '0 : w_rr_idx;
  assign w_ptr_nxt = (w_rr_idx == PW'(NUM_REQ - 1)) ? '0 : w_rr_idx + 1'b1;
  assign w_gnt_vec = w_wr_ok ? (NUM_REQ'(1) << w_gnt_idx) : '0;

  always_comb begin
    w_cnt_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_cnt_nxt = r_count + 1'b1;
      2'b01:   w_cnt_nxt = r_count - 1'b1;
      default: w_cnt_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_gnt <= '0;
      r_rd_gnt <= 1'b0;
      r_wr_sig <= 1'b0;
      r_rd_sig <= 1'b0;
      r_data   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_rr_ptr <= '0;
    end else begin
      r_wr_gnt <= w_gnt_vec;
      r_rd_gnt <= w_rd_ok;
      r_wr_sig <= w_wr_ok;
      r_rd_sig <= w_rd_ok;
      r_count  <= w_cnt_nxt;
      r_full   <= (w_cnt_nxt == CW'(DEPTH));
      r_empty  <= (w_cnt_nxt == '0);
      if (w_wr_ok) r_data <= wr_data[w_gnt_idx*DW +: DW];
      // A strict-priority grant to index 0 leaves the rotation untouched.
      if (w_wr_ok && !w_prio_hit) r_rr_ptr <= w_ptr_nxt;
    end
  end

  assign wr_gnt            = r_wr_gnt;
  assign rd_gnt            = r_rd_gnt;
  assign fifo_write_signal = r_wr_sig;
  assign fifo_read_signal  = r_rd_sig;
  assign fifo_data_in      = r_data;
  assign count             = r_count;
  assign full              = r_full;
  assign empty             = r_empty;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Directed bench for fifo_port_arbiter: the driver queues hand-computed per-cycle expectations, a negedge monitor compares.
module tb_fifo_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wr_req;
  logic [31:0] wr_data;
  logic [3:0]  wr_gnt;
  logic        rd_req;
  logic        rd_gnt;
  logic        fifo_write_signal;
  logic        fifo_read_signal;
  logic [7:0]  fifo_data_in;
  logic [4:0]  count;
  logic        full;
  logic        empty;

  fifo_port_arbiter #(.NUM_REQ(4), .DW(8), .DEPTH(16), .CW(5)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_req(wr_req), .wr_data(wr_data),
    .wr_gnt(wr_gnt), .rd_req(rd_req), .rd_gnt(rd_gnt),
    .fifo_write_signal(fifo_write_signal), .fifo_read_signal(fifo_read_signal),
    .fifo_data_in(fifo_data_in), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [21:0] exp;
    string       nm;
  } ent_t;

  ent_t        q[$];
  ent_t        cur;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [21:0] act;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      cur = q.pop_front();
      act = {wr_gnt, rd_gnt, fifo_write_signal, fifo_read_signal, fifo_data_in, count, full, empty};
      total++;
      if (act !== cur.exp) begin
        bad++;
        $display("FAIL %s: got gnt=%b rd=%b ws=%b rs=%b d=%h cnt=%0d f=%b e=%b, want gnt=%b rd=%b ws=%b rs=%b d=%h cnt=%0d f=%b e=%b",
                 cur.nm, act[21:18], act[17], act[16], act[15], act[14:7], act[6:2], act[1], act[0],
                 cur.exp[21:18], cur.exp[17], cur.exp[16], cur.exp[15], cur.exp[14:7], cur.exp[6:2], cur.exp[1], cur.exp[0]);
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic [3:0] wq, input logic rq,
                      input logic [3:0] eg, input logic erd, input logic [7:0] ed,
                      input logic [4:0] ec, input string nm);
    ent_t n;
    @(negedge clk);
    rst    = r;
    en     = e;
    wr_req = wq;
    rd_req = rq;
    n.due  = cyc + 1;
    n.exp  = {eg, erd, |eg, erd, ed, ec, (ec == 5'd16), (ec == 5'd0)};
    n.nm   = nm;
    q.push_back(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    wr_req  = 4'b0;
    rd_req  = 1'b0;
    wr_data = {8'h13, 8'h12, 8'h11, 8'h10};

    step(1, 0, 4'b0000, 0, 4'b0000, 0, 8'h00, 5'd0, "reset_idle");
    step(1, 1, 4'b1111, 1, 4'b0000, 0, 8'h00, 5'd0, "reset_with_req");

`ifdef FIFO_ARB_PRIO0_EN
    step(0, 1, 4'b1111, 0, 4'b0001, 0, 8'h10, 5'd1, "prio0_a");
    step(0, 1, 4'b1111, 0, 4'b0001, 0, 8'h10, 5'd2, "prio0_b");
    step(0, 1, 4'b1110, 0, 4'b0010, 0, 8'h11, 5'd3, "prio_rr_1");
    step(0, 1, 4'b1110, 0, 4'b0100, 0, 8'h12, 5'd4, "prio_rr_2");
    step(0, 1, 4'b1110, 0, 4'b1000, 0, 8'h13, 5'd5, "prio_rr_3");
`else
    step(0, 1, 4'b1111, 0, 4'b0001, 0, 8'h10, 5'd1, "rr_0");
    step(0, 1, 4'b1111, 0, 4'b0010, 0, 8'h11, 5'd2, "rr_1");
    step(0, 1, 4'b1111, 0, 4'b0100, 0, 8'h12, 5'd3, "rr_2");
    step(0, 1, 4'b1111, 0, 4'b1000, 0, 8'h13, 5'd4, "rr_3");
    step(0, 1, 4'b1111, 0, 4'b0001, 0, 8'h10, 5'd5, "rr_wrap");
`endif
    step(0, 1, 4'b0100, 1, 4'b0100, 1, 8'h12, 5'd5, "simultaneous");
    for (int i = 0; i < 3; i++)
      step(0, 0, 4'b1111, 1, 4'b0000, 0, 8'h12, 5'd5, "en_off");
    step(0, 1, 4'b1110, 0, 4'b1000, 0, 8'h13, 5'd6, "ptr_held");
`ifdef FIFO_ARB_PRIO0_EN
    step(0, 1, 4'b1001, 0, 4'b0001, 0, 8'h10, 5'd7, "prio0_1001_a");
    step(0, 1, 4'b1001, 0, 4'b0001, 0, 8'h10, 5'd8, "prio0_1001_b");
    step(0, 1, 4'b1001, 0, 4'b0001, 0, 8'h10, 5'd9, "prio0_1001_c");
`else
    step(0, 1, 4'b1001, 0, 4'b0001, 0, 8'h10, 5'd7, "rr_1001_a");
    step(0, 1, 4'b1001, 0, 4'b1000, 0, 8'h13, 5'd8, "rr_1001_b");
    step(0, 1, 4'b1001, 0, 4'b0001, 0, 8'h10, 5'd9, "rr_1001_c");
`endif
    step(1, 1, 4'b1111, 1, 4'b0000, 0, 8'h00, 5'd0, "reset_mid_traffic");
    step(0, 1, 4'b1111, 0, 4'b0001, 0, 8'h10, 5'd1, "ptr_after_reset");
    step(0, 1, 4'b0000, 1, 4'b0000, 1, 8'h10, 5'd0, "drain_one");
    step(0, 1, 4'b0010, 1, 4'b0010, 0, 8'h11, 5'd1, "empty_block");
    step(0, 1, 4'b0010, 1, 4'b0010, 1, 8'h11, 5'd1, "empty_then_both");
    for (int i = 0; i < 15; i++)
      step(0, 1, 4'b0100, 0, 4'b0100, 0, 8'h12, 5'(i + 2), "fill_req2");
    step(0, 1, 4'b0100, 1, 4'b0000, 1, 8'h12, 5'd15, "full_block");
    step(0, 1, 4'b0100, 1, 4'b0100, 1, 8'h12, 5'd15, "write_after_drop");
    step(0, 1, 4'b0100, 0, 4'b0100, 0, 8'h12, 5'd16, "refill");
    step(0, 1, 4'b0100, 0, 4'b0000, 0, 8'h12, 5'd16, "full_hold");
    for (int i = 0; i < 16; i++)
      step(0, 1, 4'b0000, 1, 4'b0000, 1, 8'h12, 5'(15 - i), "drain");
    step(0, 1, 4'b0000, 1, 4'b0000, 0, 8'h12, 5'd0, "empty_read_block");
    step(0, 0, 4'b0000, 0, 4'b0000, 0, 8'h12, 5'd0, "idle");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_queue: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
